// File: rtl/snn_presentation_ctrl_if.sv
// rtl/snn_presentation_ctrl_if.sv - signal bundle between sample loader, presentation controller and neuron array
interface snn_presentation_ctrl_if #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 layer_rst;
  logic                 step_en;
  logic [N_NEURONS-1:0] spike_in;
  logic [N_NEURONS-1:0] inh_out;
  logic [15:0]          step_idx;
  logic [IDX_W-1:0]     winner;
  logic [CNT_W-1:0]     winner_count;
  logic                 winner_valid;

  modport master (
    input  start, spike_in,
    output busy, done, layer_rst, step_en, inh_out, step_idx,
           winner, winner_count, winner_valid
  );

  modport slave (
    output start, spike_in,
    input  busy, done, layer_rst, step_en, inh_out, step_idx,
           winner, winner_count, winner_valid
  );
endinterface

// File: rtl/snn_presentation_ctrl.sv
// rtl/snn_presentation_ctrl.sv - one sample presentation: timestep enables, spike counting, WTA inhibition, argmax, rest
module snn_presentation_ctrl #(
  parameter int N_NEURONS   = 8,
  parameter int IDX_W       = 3,
  parameter int T_WINDOW    = 250,
  parameter int STEP_CYCLES = 23,
  parameter int REST_STEPS  = 10,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  snn_presentation_ctrl_if.master bus
);
  localparam int REST_CYC  = REST_STEPS * STEP_CYCLES;
  localparam int REST_LAST = (REST_CYC > 0) ? REST_CYC - 1 : 0;
  localparam int PH_W      = $clog2(STEP_CYCLES);
  localparam int RST_W     = (REST_CYC > 1) ? $clog2(REST_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_ARGMAX, S_REST, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [PH_W-1:0]      r_ph;
  logic [RST_W-1:0]     r_rest;
  logic [15:0]          r_step_idx;
  logic                 r_strobe;
  logic [CNT_W-1:0]     r_cnt [N_NEURONS];
  logic [N_NEURONS-1:0] r_inh;
  logic [IDX_W-1:0]     r_scan, r_max_idx, r_winner;
  logic [CNT_W-1:0]     r_max_cnt, r_winner_count;
  logic                 r_winner_valid;

  logic                 w_step_en, w_last_step, w_scan_last, w_rest_last, w_cand_gt;
  logic [IDX_W-1:0]     w_best_idx;
  logic [CNT_W-1:0]     w_best_cnt;

  assign w_step_en   = (r_state == S_RUN) && (r_ph == PH_W'(STEP_CYCLES - 1));
  assign w_last_step = w_step_en && (r_step_idx == 16'(T_WINDOW - 1));
  assign w_scan_last = (r_scan == IDX_W'(N_NEURONS - 1));
  assign w_rest_last = (r_rest == RST_W'(REST_LAST));
  // Strictly-greater compare keeps the lowest index on ties
  assign w_cand_gt   = (r_cnt[r_scan] > r_max_cnt);
  assign w_best_cnt  = w_cand_gt ? r_cnt[r_scan] : r_max_cnt;
  assign w_best_idx  = w_cand_gt ? r_scan : r_max_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ph           <= '0;
      r_rest         <= '0;
      r_step_idx     <= '0;
      r_strobe       <= 1'b0;
      r_inh          <= '0;
      r_scan         <= '0;
      r_max_idx      <= '0;
      r_max_cnt      <= '0;
      r_winner       <= '0;
      r_winner_count <= '0;
      r_winner_valid <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= '0;
    end else begin
      r_state  <= w_next;
      r_strobe <= w_step_en;
      case (r_state)
        S_CLEAR: begin
          r_ph           <= '0;
          r_step_idx     <= '0;
          r_inh          <= '0;
          r_winner       <= '0;
          r_winner_count <= '0;
          r_winner_valid <= 1'b0;
          for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= '0;
        end
        S_RUN: begin
          r_ph <= w_step_en ? '0 : r_ph + PH_W'(1);
          if (w_step_en && !w_last_step) r_step_idx <= r_step_idx + 16'd1;
        end
        S_DRAIN: begin
          r_scan    <= '0;
          r_max_cnt <= '0;
          r_max_idx <= '0;
        end
        S_ARGMAX: begin
          r_scan    <= r_scan + IDX_W'(1);
          r_max_cnt <= w_best_cnt;
          r_max_idx <= w_best_idx;
          r_rest    <= '0;
          if (w_scan_last) begin
            r_winner       <= w_best_idx;
            r_winner_count <= w_best_cnt;
            r_winner_valid <= (w_best_cnt != '0);
          end
        end
        S_REST:  r_rest <= r_rest + RST_W'(1);
        default: ;
      endcase

      // The strobe trails step_en by one cycle to line up with the array's registered spikes
      if (r_strobe && (r_state == S_RUN || r_state == S_DRAIN)) begin
        for (int i = 0; i < N_NEURONS; i++)
          if (bus.spike_in[i] && r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        r_inh <= (bus.spike_in != '0) ? ~bus.spike_in : '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_RUN;
      S_RUN:    if (w_last_step) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_ARGMAX;
      S_ARGMAX: if (w_scan_last) w_next = (REST_CYC > 0) ? S_REST : S_DONE;
      S_REST:   if (w_rest_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    bus.busy         = (r_state != S_IDLE);
    bus.done         = (r_state == S_DONE);
    bus.layer_rst    = (r_state == S_CLEAR) || (r_state == S_REST);
    bus.step_en      = w_step_en;
    bus.inh_out      = (r_state == S_RUN || r_state == S_DRAIN) ? r_inh : '0;
    bus.step_idx     = r_step_idx;
    bus.winner       = r_winner;
    bus.winner_count = r_winner_count;
    bus.winner_valid = r_winner_valid;
  end
endmodule

// File: tb/tb_snn_presentation_ctrl.sv
// tb/tb_snn_presentation_ctrl.sv - scoreboard bench for snn_presentation_ctrl
module tb_snn_presentation_ctrl;
  localparam int N = 4, IW = 2, T = 5, S = 3, R = 2, CW = 16, CW2 = 2;
  localparam int LAT = 1 + T*S + 1 + N + R*S + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_presentation_ctrl_if #(.N_NEURONS(N), .IDX_W(IW), .CNT_W(CW))  bus ();
  snn_presentation_ctrl_if #(.N_NEURONS(N), .IDX_W(IW), .CNT_W(CW2)) bus2 ();
  assign bus2.start    = bus.start;
  assign bus2.spike_in = bus.spike_in;

  snn_presentation_ctrl #(.N_NEURONS(N), .IDX_W(IW), .T_WINDOW(T), .STEP_CYCLES(S),
    .REST_STEPS(R), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  snn_presentation_ctrl #(.N_NEURONS(N), .IDX_W(IW), .T_WINDOW(T), .STEP_CYCLES(S),
    .REST_STEPS(R), .CNT_W(CW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [IW-1:0]  w;
    logic [CW-1:0]  c;
    logic           v;
    logic [IW-1:0]  w2;
    logic [CW2-1:0] c2;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_errors = 0;
  logic [N-1:0] pat [T];
  int obs_lat, ctl_err, ctl_first, done_cnt;
  logic [IW-1:0]  obs_w, obs_w2;
  logic [CW-1:0]  obs_c;
  logic [CW2-1:0] obs_c2;
  logic           obs_v;

  // Drives one presentation and records observations against a cycle-exact control model
  task automatic present(input bit hold_all, input bit poke);
    bit prev_en = 1'b0;
    int si = 0;
    logic [N-1:0] m_inh = '0, e_inh;
    logic [15:0] m_step = '0;
    logic e_en, e_lrst, e_busy, e_done;
    ctl_err = 0; ctl_first = -1; done_cnt = 0; obs_lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.spike_in = hold_all ? '1 : '0;
    for (int k = 1; k <= LAT + 12; k++) begin
      @(negedge clk);
      bus.start = poke && (k == 8 || k == LAT - 3);
      e_busy = (k <= LAT);
      e_done = (k == LAT);
      e_lrst = (k == 1) || (k >= LAT - R*S && k < LAT);
      e_en   = (k >= 2 && k <= 1 + T*S && ((k - 2) % S) == S - 1);
      e_inh  = (k >= 2 && k <= 2 + T*S) ? m_inh : '0;
      if (bus.step_en !== e_en || bus.layer_rst !== e_lrst || bus.busy !== e_busy ||
          bus.done !== e_done || bus.inh_out !== e_inh ||
          (k >= 2 && k <= LAT && bus.step_idx !== m_step)) begin
        ctl_err++;
        if (ctl_first < 0) ctl_first = k;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (obs_lat < 0) begin
          obs_lat = k;
          obs_w = bus.winner; obs_c = bus.winner_count; obs_v = bus.winner_valid;
          obs_w2 = bus2.winner; obs_c2 = bus2.winner_count;
        end
      end
      if (e_en && m_step != 16'(T - 1)) m_step = m_step + 16'd1;
      if (prev_en) begin
        bus.spike_in = hold_all ? '1 : pat[si];
        si++;
        m_inh = (bus.spike_in != '0) ? ~bus.spike_in : '0;
      end else begin
        bus.spike_in = hold_all ? '1 : N'($urandom);
      end
      prev_en = e_en;
    end
    bus.start = 1'b0;
    bus.spike_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.spike_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.layer_rst, bus.step_en, bus.winner_valid} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b want 00000",
        {bus.busy, bus.done, bus.layer_rst, bus.step_en, bus.winner_valid});
    end
    n_checks++;
    if (bus.inh_out !== '0 || bus.step_idx !== '0) begin
      n_errors++; $display("FAIL reset_inh_step: got inh=%b step=%0d want 0", bus.inh_out, bus.step_idx);
    end
    n_checks++;
    if (bus.winner !== '0 || bus.winner_count !== '0 || bus2.busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_winner: got w=%0d c=%0d busy2=%b want 0", bus.winner, bus.winner_count, bus2.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_presentation(input string name, input bit hold_all, input bit poke);
    exp_t e;
    present(hold_all, poke);
    e = sb.pop_front();
    n_checks++;
    if (obs_lat !== LAT) begin n_errors++; $display("FAIL %s latency: got %0d want %0d", name, obs_lat, LAT); end
    n_checks++;
    if (ctl_err !== 0) begin n_errors++; $display("FAIL %s control: got %0d bad cycles (first %0d) want 0", name, ctl_err, ctl_first); end
    n_checks++;
    if (done_cnt !== 1) begin n_errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
    n_checks++;
    if (obs_w !== e.w || obs_c !== e.c || obs_v !== e.v) begin
      n_errors++; $display("FAIL %s winner: got w=%0d c=%0d v=%b want w=%0d c=%0d v=%b", name, obs_w, obs_c, obs_v, e.w, e.c, e.v);
    end
    n_checks++;
    if (obs_w2 !== e.w2 || obs_c2 !== e.c2) begin
      n_errors++; $display("FAIL %s winner_sat: got w=%0d c=%0d want w=%0d c=%0d", name, obs_w2, obs_c2, e.w2, e.c2);
    end
  endtask

  task automatic test_no_spikes();
    pat = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    sb.push_back('{w: 2'd0, c: 16'd0, v: 1'b0, w2: 2'd0, c2: 2'd0});
    test_presentation("no_spikes", 1'b0, 1'b0);
  endtask

  task automatic test_single_winner();
    pat = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    sb.push_back('{w: 2'd2, c: 16'd5, v: 1'b1, w2: 2'd2, c2: 2'd3});
    test_presentation("single_winner", 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    pat = '{4'b0010, 4'b0010, 4'b1010, 4'b1000, 4'b1001};
    sb.push_back('{w: 2'd1, c: 16'd3, v: 1'b1, w2: 2'd1, c2: 2'd3});
    test_presentation("tie", 1'b0, 1'b0);
  endtask

  task automatic test_strobe_only();
    sb.push_back('{w: 2'd0, c: 16'd5, v: 1'b1, w2: 2'd0, c2: 2'd3});
    test_presentation("strobe_only", 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    pat = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001};
    sb.push_back('{w: 2'd0, c: 16'd3, v: 1'b1, w2: 2'd0, c2: 2'd3});
    test_presentation("start_ignored", 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    bit hit = 1'b0;
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.spike_in = 4'b0010;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.step_idx === 16'd2) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin n_errors++; $display("FAIL abort_reach_step2: got no step_idx=2 want step_idx=2 within 40 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.layer_rst, bus.step_en, bus.winner_valid} !== 5'b0 ||
        bus.inh_out !== '0 || bus.step_idx !== '0 || bus.winner_count !== '0) begin
      n_errors++; $display("FAIL abort_outputs: got busy=%b lrst=%b step=%0d inh=%b want all 0",
        bus.busy, bus.layer_rst, bus.step_idx, bus.inh_out);
    end
    rst = 1'b0; bus.spike_in = '0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
    pat = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    sb.push_back('{w: 2'd2, c: 16'd5, v: 1'b1, w2: 2'd2, c2: 2'd3});
    test_presentation("after_abort", 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_spikes();
    test_single_winner();
    test_tie();
    test_strobe_only();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
